// File: rtl/dsp_config_loader.sv
// Host-side feeder for the DSP slice configuration chain: accepts parallel words over
// valid/ready and shifts them MSB first into the slice, counting exactly CFG_BITS bits.
module dsp_config_loader #(
   parameter int WORD_W   = 32,
   parameter int CFG_BITS = 512
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              start,
   input  logic [WORD_W-1:0] cfg_word,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              configuration_input,
   output logic              configuration_enable,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = $clog2(CFG_BITS + 1);
   localparam int WB_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_WORD,
      SHIFT,
      DONE
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [WORD_W-1:0] shreg;
   logic [CNT_W-1:0]  bit_cnt;
   logic [WB_W-1:0]   word_bit;

   logic              last_chain_bit;
   logic              last_word_bit;
   logic              load_word;
   logic              clr_cnt;

   assign last_chain_bit = (bit_cnt == CNT_W'(CFG_BITS - 1));
   assign last_word_bit  = (word_bit == WB_W'(WORD_W - 1));

   always_ff @(posedge clk) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Chain end wins over word end, so surplus bits of the final word are never shifted
   // and no extra word is requested.
   always_comb begin
      next_state = state;
      cfg_ready  = 1'b0;
      load_word  = 1'b0;
      clr_cnt    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = WAIT_WORD;
               clr_cnt    = 1'b1;
            end
         end
         WAIT_WORD: begin
            cfg_ready = 1'b1;
            if (cfg_valid) begin
               load_word  = 1'b1;
               next_state = SHIFT;
            end
         end
         SHIFT: begin
            if (last_chain_bit) begin
               next_state = DONE;
            end else if (last_word_bit) begin
               cfg_ready = 1'b1;
               if (cfg_valid) begin
                  load_word = 1'b1;
               end else begin
                  next_state = WAIT_WORD;
               end
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // A reload in the final SHIFT cycle overrides the shift so the next word's MSB
   // follows with no bubble.
   always_ff @(posedge clk) begin
      if (RST) begin
         shreg    <= '0;
         bit_cnt  <= '0;
         word_bit <= '0;
      end else begin
         if (clr_cnt) begin
            bit_cnt <= '0;
         end
         if (state == SHIFT) begin
            shreg    <= shreg << 1;
            bit_cnt  <= bit_cnt + CNT_W'(1);
            word_bit <= word_bit + WB_W'(1);
         end
         if (load_word) begin
            shreg    <= cfg_word;
            word_bit <= '0;
         end
      end
   end

   assign configuration_enable = (state == SHIFT);
   assign configuration_input  = (state == SHIFT) & shreg[WORD_W-1];
   assign busy                 = (state != IDLE);
   assign done                 = (state == DONE);

endmodule
